// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle instruction sequencer. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Memory accesses use a req/ack
// handshake that is guarded by a timeout watchdog. Datapath strobes are
// decoded from the current state and the latched opcode (Moore style). The
// only exceptions are IRWrite/PCWrite, which follow mem_ack in FETCH, and
// PCWrite, which follows zero in EXEC of BEQ.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   opcode         instruction opcode, latched when FETCH is acknowledged
//   mem_ack        memory acknowledge (only looked at while mem_req=1)
//   zero           ALU zero flag, used for BEQ in EXEC
//   err_clr        leaves the ERROR state
//   mem_req        memory request (FETCH, MEM)
//   MemRead        read access (FETCH, MEM of LW)
//   MemWrite       write access (MEM of SW)
//   IRWrite        instruction register load (FETCH ack)
//   PCWrite        PC load (FETCH ack, taken BEQ)
//   ALUControl     00 ADD, 01 SUB, 10 AND, 11 OR (driven in EXEC)
//   ALUSrc         immediate operand select (ADDI, LW, SW in EXEC)
//   Branch         BEQ in EXEC
//   RegWrite       register file write (WB)
//   state          FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERROR=5
//   err_code       00 none, 01 illegal opcode, 10 memory timeout
//   instret        retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int OPCODE_W  = 4,
  parameter int ALUCTRL_W = 2,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 mem_ack,
  input  logic                 zero,
  input  logic                 err_clr,
  output logic                 mem_req,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 ALUSrc,
  output logic                 Branch,
  output logic                 RegWrite,
  output logic [2:0]           state,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_BEQ  = 3'd7;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t                r_state;
  state_t                w_next;
  logic [OPCODE_W-1:0]   r_op;
  logic [1:0]            r_err;
  logic [1:0]            w_err_next;
  logic [CNT_W-1:0]      r_instret;
  logic [WAIT_W-1:0]     r_wait;
  logic                  w_retire;
  logic                  w_timeout;
  logic                  w_illegal;
  logic [2:0]            w_op3;

  logic                  w_mem_req;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_ir_write;
  logic                  w_pc_write;
  logic [1:0]            w_alu;
  logic                  w_alu_src;
  logic                  w_branch;
  logic                  w_reg_write;

  // ALU operation for a legal opcode: memory ops and ADDI add, BEQ subtracts.
  function automatic logic [1:0] alu_code(input logic [2:0] op);
    logic [1:0] code;
    case (op)
      OP_SUB:  code = 2'b01;
      OP_AND:  code = 2'b10;
      OP_OR:   code = 2'b11;
      OP_BEQ:  code = 2'b01;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  assign w_op3     = r_op[2:0];
  assign w_illegal = (r_op > OPCODE_W'(7));
  // The final waiting cycle is the TIMEOUT-th one; an ack in that cycle still wins.
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  // Next-state, error-code and strobe decode.
  always_comb begin
    w_next      = r_state;
    w_err_next  = r_err;
    w_retire    = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_alu       = 2'b00;
    w_alu_src   = 1'b0;
    w_branch    = 1'b0;
    w_reg_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_mem_read = 1'b1;
        if (mem_ack) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_err_next = ERR_TIMEOUT;
          w_next     = S_ERROR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_err_next = ERR_ILLEGAL;
          w_next     = S_ERROR;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu     = alu_code(w_op3);
        w_alu_src = (w_op3 == OP_ADDI) || (w_op3 == OP_LW) || (w_op3 == OP_SW);
        case (w_op3)
          OP_LW, OP_SW: w_next = S_MEM;
          OP_BEQ: begin
            w_branch   = 1'b1;
            w_pc_write = zero;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_mem_req   = 1'b1;
        w_mem_read  = (w_op3 == OP_LW);
        w_mem_write = (w_op3 != OP_LW);
        if (mem_ack) begin
          if (w_op3 == OP_LW) begin
            w_next = S_WB;
          end else begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end else if (w_timeout) begin
          w_err_next = ERR_TIMEOUT;
          w_next     = S_ERROR;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_ERROR: begin
        if (err_clr) begin
          w_err_next = ERR_NONE;
          w_next     = S_FETCH;
        end else begin
          w_next = S_ERROR;
        end
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // State, latched opcode, error code, wait counter and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_err     <= ERR_NONE;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
      if ((r_state == S_FETCH) && mem_ack) begin
        r_op <= opcode;
      end else begin
        r_op <= r_op;
      end
      // Every state entry restarts the count; only waiting states accumulate.
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
        r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end else begin
        r_instret <= r_instret;
      end
    end
  end

  // Strobes are forced low while reset is held so an aborted access is dropped at once.
  assign mem_req    = rst_n & w_mem_req;
  assign MemRead    = rst_n & w_mem_read;
  assign MemWrite   = rst_n & w_mem_write;
  assign IRWrite    = rst_n & w_ir_write;
  assign PCWrite    = rst_n & w_pc_write;
  assign ALUControl = rst_n ? ALUCTRL_W'(w_alu) : '0;
  assign ALUSrc     = rst_n & w_alu_src;
  assign Branch     = rst_n & w_branch;
  assign RegWrite   = rst_n & w_reg_write;
  assign state      = r_state;
  assign err_code   = r_err;
  assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed bench: each cycle's expected outputs are queued when the inputs are
// driven and popped and compared on the falling edge.
// Strobe vector layout: {mem_req, MemRead, MemWrite, IRWrite, PCWrite,
//                        ALUSrc, Branch, RegWrite, ALUControl[1:0]}
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        mem_ack;
  logic        zero;
  logic        err_clr;
  logic        mem_req;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  ALUControl;
  logic        ALUSrc;
  logic        Branch;
  logic        RegWrite;
  logic [2:0]  state;
  logic [1:0]  err_code;
  logic [15:0] instret;

  multicycle_control_unit #(
    .OPCODE_W(4), .ALUCTRL_W(2), .TIMEOUT(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ack(mem_ack),
    .zero(zero), .err_clr(err_clr), .mem_req(mem_req), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .ALUControl(ALUControl), .ALUSrc(ALUSrc), .Branch(Branch),
    .RegWrite(RegWrite), .state(state), .err_code(err_code), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [9:0]  v;
    logic [1:0]  e;
    logic [15:0] i;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   ir    = 0;
  string sec  = "";

  wire [9:0] dut_vec = {mem_req, MemRead, MemWrite, IRWrite, PCWrite,
                        ALUSrc, Branch, RegWrite, ALUControl};

  localparam logic [9:0] V_ZERO  = 10'b00_0000_0000;
  localparam logic [9:0] V_FACK  = 10'b11_0110_0000;
  localparam logic [9:0] V_FWAIT = 10'b11_0000_0000;
  localparam logic [9:0] V_MRD   = 10'b11_0000_0000;
  localparam logic [9:0] V_MWR   = 10'b10_1000_0000;
  localparam logic [9:0] V_WB    = 10'b00_0000_0100;

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                         ST_M = 3'd3, ST_W = 3'd4, ST_X = 3'd5;

  function automatic logic [9:0] v_exec(input logic pc, input logic src,
                                        input logic br, input logic [1:0] alu);
    return {5'b00000, 1'b0, 1'b0, 1'b0, 2'b00} | {3'b000, 1'b0, pc, src, br, 1'b0, alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare on falling edge.
  task automatic cyc(input logic ack, input logic z, input logic clr,
                     input logic [3:0] op, input logic [2:0] es,
                     input logic [9:0] ev, input logic [1:0] ee);
    exp_t e;
    mem_ack = ack; zero = z; err_clr = clr; opcode = op;
    e.st = es; e.v = ev; e.e = ee; e.i = 16'(ir);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("%s c%0d state", sec, cyc_n), 32'(state), 32'(e.st));
    chk($sformatf("%s c%0d strobes", sec, cyc_n), 32'(dut_vec), 32'(e.v));
    chk($sformatf("%s c%0d err_code", sec, cyc_n), 32'(err_code), 32'(e.e));
    chk($sformatf("%s c%0d instret", sec, cyc_n), 32'(instret), 32'(e.i));
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] alu_tbl [8];
  logic       src_tbl [8];

  initial begin
    alu_tbl = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
    src_tbl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; opcode = 4'd0; mem_ack = 1'b0; zero = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    sec = "reset";
    chk("reset state", 32'(state), 32'(ST_F));
    chk("reset strobes", 32'(dut_vec), 32'(V_ZERO));
    chk("reset err_code", 32'(err_code), 32'(2'b00));
    chk("reset instret", 32'(instret), 32'(16'd0));
    rst_n = 1'b1;

    // ADD with immediate ack: 4 cycles
    sec = "add";
    cyc(1'b1, 1'b0, 1'b0, 4'd0, ST_F, V_FACK, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_D, V_ZERO, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_E, v_exec(1'b0, 1'b0, 1'b0, 2'b00), 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_W, V_WB, 2'b00);
    ir = 1;

    // Opcode sweep 0..7 with immediate acks, zero=0
    sec = "sweep";
    for (int op = 0; op < 8; op++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'(op), ST_F, V_FACK, 2'b00);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_D, V_ZERO, 2'b00);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_E,
          v_exec(1'b0, src_tbl[op], (op == 7), alu_tbl[op]), 2'b00);
      if (op == 5) begin
        cyc(1'b1, 1'b0, 1'b0, 4'd0, ST_M, V_MRD, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_W, V_WB, 2'b00);
      end else if (op == 6) begin
        cyc(1'b1, 1'b0, 1'b0, 4'd0, ST_M, V_MWR, 2'b00);
      end else if (op != 7) begin
        cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_W, V_WB, 2'b00);
      end
      ir++;
    end

    // BEQ taken then not taken: 3 cycles each
    sec = "beq";
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd7, ST_F, V_FACK, 2'b00);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_D, V_ZERO, 2'b00);
      cyc(1'b0, (k == 0), 1'b0, 4'd0, ST_E,
          v_exec((k == 0), 1'b0, 1'b1, 2'b01), 2'b00);
      ir++;
    end

    // LW with ack delayed 5 cycles in MEM: 10 cycles in total
    sec = "lw_wait";
    cyc(1'b1, 1'b0, 1'b0, 4'd5, ST_F, V_FACK, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_D, V_ZERO, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_E, v_exec(1'b0, 1'b1, 1'b0, 2'b00), 2'b00);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_M, V_MRD, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, ST_M, V_MRD, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_W, V_WB, 2'b00);
    ir++;

    // Illegal opcode, error hold, err_clr
    sec = "illegal";
    cyc(1'b1, 1'b0, 1'b0, 4'd8, ST_F, V_FACK, 2'b00);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, ST_D, V_ZERO, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, ST_X, V_ZERO, 2'b01);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_X, V_ZERO, 2'b01);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, ST_X, V_ZERO, 2'b01);

    // Fetch timeout: 16 cycles without ack
    sec = "timeout";
    for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_F, V_FWAIT, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_X, V_ZERO, 2'b10);
    cyc(1'b0, 1'b0, 1'b1, 4'd0, ST_X, V_ZERO, 2'b10);

    // Ack on the last allowed cycle wins over the timeout
    sec = "ack_last";
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_F, V_FWAIT, 2'b00);
    cyc(1'b1, 1'b0, 1'b0, 4'd1, ST_F, V_FACK, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_D, V_ZERO, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_E, v_exec(1'b0, 1'b0, 1'b0, 2'b01), 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_W, V_WB, 2'b00);
    ir++;

    // Reset in MEM of SW aborts it
    sec = "sw_reset";
    cyc(1'b1, 1'b0, 1'b0, 4'd6, ST_F, V_FACK, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_D, V_ZERO, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_E, v_exec(1'b0, 1'b1, 1'b0, 2'b00), 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_M, V_MWR, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("abort state", 32'(state), 32'(ST_F));
    chk("abort strobes", 32'(dut_vec), 32'(V_ZERO));
    chk("abort err_code", 32'(err_code), 32'(2'b00));
    chk("abort instret", 32'(instret), 32'(16'd0));
    ir = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sec = "resume";
    cyc(1'b1, 1'b0, 1'b0, 4'd3, ST_F, V_FACK, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_D, V_ZERO, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_E, v_exec(1'b0, 1'b0, 1'b0, 2'b11), 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_W, V_WB, 2'b00);
    ir = 1;
    cyc(1'b0, 1'b0, 1'b0, 4'd0, ST_F, V_FWAIT, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
